spike_count_accumulator: RTL

Transmit-side companion of the muscle force model. Collapses a per-cycle population spike vector from the motor-neuron array into one integer spike count per simulation step, and presents it held-stable on a 32-bit bus. That bus feeds the muscle's `i_spike_cnt` input, which converts it to floating point and drives the twitch filter. The block is a two-stage pipeline (population count, then window accumulate/latch) with saturation and a per-window status flag.

---
 rtl/spike_count_accumulator.sv | 98 +++++++++
 1 files changed

// File: rtl/spike_count_accumulator.sv
// spike_count_accumulator: per-step population spike counter feeding the muscle model.
// Stage 1 registers the popcount of the spike vector. Stage 2 adds it into a
// saturating window accumulator and, on a step, latches the window total.
//
// Ports:
//   clk            rising-edge system clock
//   reset          synchronous active-high reset
//   i_spike_vec    NN-bit spike vector, one bit per neuron
//   i_spike_valid  qualifies i_spike_vec (0 = no spikes this cycle)
//   i_step         last cycle of the current window
//   o_spike_cnt    count of last completed window, zero-extended, held
//   o_cnt_valid    one-cycle pulse when o_spike_cnt updates
//   o_sat          last completed window saturated
//   o_window_idx   completed windows since reset (wraps)
module spike_count_accumulator #(
    parameter int NN    = 32,
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NN-1:0] i_spike_vec,
    input  logic          i_spike_valid,
    input  logic          i_step,
    output logic [31:0]   o_spike_cnt,
    output logic          o_cnt_valid,
    output logic          o_sat,
    output logic [31:0]   o_window_idx
);

    localparam int PC_W = $clog2(NN + 1);

    logic [PC_W-1:0]  w_pc;
    logic [PC_W-1:0]  w_pc_in;
    logic [CNT_W:0]   w_sum;
    logic             w_ovf;
    logic [CNT_W-1:0] w_sat_sum;
    logic             w_sat_hit;

    logic [PC_W-1:0]  r_pc;
    logic             r_step;
    logic [CNT_W-1:0] r_acc;
    logic             r_acc_sat;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cnt_valid;
    logic             r_sat;
    logic [31:0]      r_idx;

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < NN; i++) begin
            w_pc = w_pc + PC_W'(i_spike_vec[i]);
        end
    end

    assign w_pc_in = i_spike_valid ? w_pc : '0;

    // One extra bit on the sum exposes overflow of the CNT_W accumulator.
    assign w_sum     = {1'b0, r_acc} + (CNT_W + 1)'(r_pc);
    assign w_ovf     = w_sum[CNT_W];
    assign w_sat_sum = w_ovf ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    // Saturation is sticky for the rest of the window.
    assign w_sat_hit = w_ovf | r_acc_sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= '0;
            r_step      <= 1'b0;
            r_acc       <= '0;
            r_acc_sat   <= 1'b0;
            r_cnt       <= '0;
            r_cnt_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_idx       <= '0;
        end else begin
            r_pc   <= w_pc_in;
            r_step <= i_step;
            if (r_step) begin
                // Closing cycle's spikes join the window being reported.
                r_cnt       <= w_sat_sum;
                r_sat       <= w_sat_hit;
                r_cnt_valid <= 1'b1;
                r_idx       <= r_idx + 32'd1;
                r_acc       <= '0;
                r_acc_sat   <= 1'b0;
            end else begin
                r_acc       <= w_sat_sum;
                r_acc_sat   <= w_sat_hit;
                r_cnt_valid <= 1'b0;
            end
        end
    end

    assign o_spike_cnt  = 32'(r_cnt);
    assign o_cnt_valid  = r_cnt_valid;
    assign o_sat        = r_sat;
    assign o_window_idx = r_idx;

endmodule
